qif_synapse: RTL

- Synaptic current generator feeding the QIF neuron's signed 8-bit synaptic current input; this is the drive side of the neuron's I_syn interface.
- Accepts weighted spike events over a valid/ready handshake and accumulates each weight into a saturating signed current.
- The current decays exponentially toward zero on a prescaled tick.
- A refractory window after each accepted spike back-pressures the spike source.

---
 rtl/qif_pkg.sv | 28 ++
 rtl/qif_synapse_if.sv | 18 +
 rtl/qif_sat_add.sv | 16 +
 rtl/qif_synapse.sv | 127 ++++++++++++
 4 files changed

// File: rtl/qif_pkg.sv
// rtl/qif_pkg.sv - shared types, limits and saturation helper for the QIF neuron and synapse
package qif_pkg;

    // Synapse drive-side FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        REFRACT = 2'd2
    } qif_state_t;

    // Signed 8-bit synaptic / membrane current
    typedef logic signed [7:0] qif_cur_t;

    localparam qif_cur_t I_MAX = 8'sd127;
    localparam qif_cur_t I_MIN = -8'sd128;

    // Clamp a 9-bit signed intermediate back into the 8-bit current range
    function automatic qif_cur_t sat_to_cur(input logic signed [8:0] v);
        if (v > 9'sd127) begin
            return I_MAX;
        end else if (v < -9'sd128) begin
            return I_MIN;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/qif_synapse_if.sv
// rtl/qif_synapse_if.sv - weighted spike handshake between a spike source and the synapse
interface qif_synapse_if;
    logic              spike_valid;
    logic signed [7:0] spike_weight;
    logic              spike_ready;

    modport master (
        output spike_valid,
        output spike_weight,
        input  spike_ready
    );

    modport slave (
        input  spike_valid,
        input  spike_weight,
        output spike_ready
    );
endinterface

// File: rtl/qif_sat_add.sv
// rtl/qif_sat_add.sv - combinational signed 8-bit add with clamp to [-128, 127]
module qif_sat_add
    import qif_pkg::*;
(
    input  qif_cur_t a,
    input  qif_cur_t b,
    output qif_cur_t y
);
    logic signed [8:0] sum9;

    // Widen by one bit so the true sum is exact before clamping
    always_comb begin
        sum9 = {a[7], a} + {b[7], b};
        y    = sat_to_cur(sum9);
    end
endmodule

// File: rtl/qif_synapse.sv
// rtl/qif_synapse.sv - saturating, exponentially decaying synaptic current driven by weighted spikes
module qif_synapse
    import qif_pkg::*;
#(
    parameter int DECAY_DIV     = 4,
    parameter int DECAY_SHIFT   = 2,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    qif_synapse_if.slave      spk,
    output logic signed [7:0] I_syn,
    output logic              active,
    output logic [7:0]        spike_cnt
);
    localparam logic [7:0] PRE_LAST  = 8'(DECAY_DIV - 1);
    localparam logic [7:0] REFR_LOAD = 8'(REFRAC_CYCLES - 1);

    qif_state_t state, state_nxt;
    logic [7:0] refr_cnt, refr_nxt;
    logic [7:0] pre_cnt;
    logic       tick;
    logic       accept;
    logic       ready;

    qif_cur_t   shr;
    qif_cur_t   dec_term;
    qif_cur_t   dec_neg;
    qif_cur_t   decayed;
    qif_cur_t   add_w;
    qif_cur_t   next_cur;
    logic       next_zero;

    assign tick      = (pre_cnt == PRE_LAST);
    assign ready     = (state != REFRACT);
    assign accept    = spk.spike_valid && ready;
    assign spk.spike_ready = ready;
    assign active    = (I_syn != 8'sd0);
    assign next_zero = (next_cur == 8'sd0);

    // Free-running decay prescaler, independent of spike traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= 8'd0;
        end else if (tick) begin
            pre_cnt <= 8'd0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    // Decay step: arithmetic shift, forced to 1 for small positives so the current always reaches 0
    always_comb begin
        shr      = I_syn >>> DECAY_SHIFT;
        dec_term = shr;
        if ((shr == 8'sd0) && (I_syn > 8'sd0)) begin
            dec_term = 8'sd1;
        end
        dec_neg = tick ? -dec_term : 8'sd0;
        add_w   = accept ? spk.spike_weight : 8'sd0;
    end

    // Decay first; the magnitude only shrinks so this never actually clamps
    qif_sat_add u_decay_add (
        .a (I_syn),
        .b (dec_neg),
        .y (decayed)
    );

    // Weight accumulation on top of the decayed current, saturating
    qif_sat_add u_weight_add (
        .a (decayed),
        .b (add_w),
        .y (next_cur)
    );

    // Current register and accepted-spike counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            I_syn     <= 8'sd0;
            spike_cnt <= 8'd0;
        end else begin
            I_syn <= next_cur;
            if (accept) begin
                spike_cnt <= spike_cnt + 8'd1;
            end
        end
    end

    // FSM state and refractory countdown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            refr_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            refr_cnt <= refr_nxt;
        end
    end

    // Next-state logic: an accept opens the refractory window, otherwise track whether current is nonzero
    always_comb begin
        state_nxt = state;
        refr_nxt  = refr_cnt;
        case (state)
            IDLE, ACTIVE: begin
                if (accept && (REFRAC_CYCLES != 0)) begin
                    state_nxt = REFRACT;
                    refr_nxt  = REFR_LOAD;
                end else begin
                    state_nxt = next_zero ? IDLE : ACTIVE;
                end
            end
            REFRACT: begin
                if (refr_cnt == 8'd0) begin
                    state_nxt = next_zero ? IDLE : ACTIVE;
                end else begin
                    refr_nxt = refr_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                refr_nxt  = 8'd0;
            end
        endcase
    end
endmodule
